// File: rtl/alu_operand_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_operand_stage_if
// Description : Issue / ALU / writeback / load / debug signal bundle for
//               alu_operand_stage. "master" drives commands and the ALU
//               result; "slave" is the operand stage itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_operand_stage_if #(
  parameter int DW  = 32,
  parameter int AW  = 5,
  parameter int OPW = 5
);
  logic           in_valid;
  logic           in_ready;
  logic [OPW-1:0] in_op;
  logic [AW-1:0]  in_ra;
  logic [AW-1:0]  in_rb;
  logic [AW-1:0]  in_rd;
  logic [DW-1:0]  alu_a;
  logic [DW-1:0]  alu_b;
  logic [OPW-1:0] alu_op;
  logic [DW-1:0]  alu_out;
  logic           wb_valid;
  logic [AW-1:0]  wb_rd;
  logic [DW-1:0]  wb_data;
  logic           ld_en;
  logic [AW-1:0]  ld_addr;
  logic [DW-1:0]  ld_data;
  logic [AW-1:0]  dbg_addr;
  logic [DW-1:0]  dbg_data;

  modport master (
    output in_valid, in_op, in_ra, in_rb, in_rd, alu_out,
           ld_en, ld_addr, ld_data, dbg_addr,
    input  in_ready, alu_a, alu_b, alu_op, wb_valid, wb_rd, wb_data, dbg_data
  );

  modport slave (
    input  in_valid, in_op, in_ra, in_rb, in_rd, alu_out,
           ld_en, ld_addr, ld_data, dbg_addr,
    output in_ready, alu_a, alu_b, alu_op, wb_valid, wb_rd, wb_data, dbg_data
  );
endinterface
`default_nettype wire

// File: rtl/alu_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_operand_stage
// Description : Operand-issue and writeback stage around a combinational ALU.
//               Register file, registered ALU operands (E stage) and a
//               registered writeback (W stage). Optional feature macro:
//               ALU_WB_BYPASS_EN - forward alu_out into the operand registers
//               on a read-after-write hazard instead of stalling one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_operand_stage #(
  parameter int DW  = 32,
  parameter int AW  = 5,
  parameter int OPW = 5
) (
  input  wire                 clk,
  input  wire                 rst,
  alu_operand_stage_if.slave  bus
);
  localparam int       c_NREG  = 2 ** AW;
  localparam [OPW-1:0] c_A_NOP = '0;

  logic [DW-1:0]  r_regs [0:c_NREG-1];
  logic [DW-1:0]  r_alu_a;
  logic [DW-1:0]  r_alu_b;
  logic [OPW-1:0] r_alu_op;
  logic [AW-1:0]  r_e_rd;
  logic           r_e_valid;
  logic           r_wb_valid;
  logic [AW-1:0]  r_wb_rd;
  logic [DW-1:0]  r_wb_data;

  logic           w_wb_do;
  logic           w_e_wr;
  logic           w_fwd_a;
  logic           w_fwd_b;
  logic           w_in_ready;
  logic           w_issue;
  logic [DW-1:0]  w_opnd_a;
  logic [DW-1:0]  w_opnd_b;

  // The E stage produces a writeback whenever it holds a real (non-NOP) op.
  assign w_wb_do = r_e_valid && (r_alu_op != c_A_NOP);
  // Only writebacks to a non-zero register change what a reader would see.
  assign w_e_wr  = w_wb_do && (r_e_rd != '0);
  assign w_fwd_a = w_e_wr && (bus.in_ra == r_e_rd);
  assign w_fwd_b = w_e_wr && (bus.in_rb == r_e_rd);

`ifdef ALU_WB_BYPASS_EN
  // Hazard operands come straight from the ALU result being written back.
  assign w_in_ready = !rst;
  assign w_opnd_a   = w_fwd_a ? bus.alu_out : r_regs[bus.in_ra];
  assign w_opnd_b   = w_fwd_b ? bus.alu_out : r_regs[bus.in_rb];
`else
  // Hazard stalls one cycle; the operand is then read from the regfile.
  assign w_in_ready = !rst && !(w_fwd_a || w_fwd_b);
  assign w_opnd_a   = r_regs[bus.in_ra];
  assign w_opnd_b   = r_regs[bus.in_rb];
`endif

  assign w_issue = bus.in_valid && w_in_ready;

  // Register file: direct load first, writeback last so it wins a collision;
  // register 0 is never written so it always reads back as zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < c_NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      if (bus.ld_en && (bus.ld_addr != '0)) begin
        r_regs[bus.ld_addr] <= bus.ld_data;
      end
      if (w_e_wr) begin
        r_regs[r_e_rd] <= bus.alu_out;
      end
    end
  end

  // E stage: capture operands on issue, otherwise present a NOP to the ALU.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_op  <= c_A_NOP;
      r_e_rd    <= '0;
      r_e_valid <= 1'b0;
    end else if (w_issue) begin
      r_alu_a   <= w_opnd_a;
      r_alu_b   <= w_opnd_b;
      r_alu_op  <= bus.in_op;
      r_e_rd    <= bus.in_rd;
      r_e_valid <= 1'b1;
    end else begin
      r_alu_op  <= c_A_NOP;
      r_e_valid <= 1'b0;
    end
  end

  // W stage: one-cycle writeback pulse with its destination and value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb_valid <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
    end else if (w_wb_do) begin
      r_wb_valid <= 1'b1;
      r_wb_rd    <= r_e_rd;
      r_wb_data  <= bus.alu_out;
    end else begin
      r_wb_valid <= 1'b0;
    end
  end

  assign bus.in_ready = w_in_ready;
  assign bus.alu_a    = r_alu_a;
  assign bus.alu_b    = r_alu_b;
  assign bus.alu_op   = r_alu_op;
  assign bus.wb_valid = r_wb_valid;
  assign bus.wb_rd    = r_wb_rd;
  assign bus.wb_data  = r_wb_data;
  assign bus.dbg_data = r_regs[bus.dbg_addr];
endmodule
`default_nettype wire

// File: tb/tb_alu_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_operand_stage
// Description : Self-checking bench for alu_operand_stage: directed scenarios
//               followed by random issue traffic against an architectural
//               register model. Honours ALU_WB_BYPASS_EN for timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_operand_stage;
  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int OPW = 5;

`ifdef ALU_WB_BYPASS_EN
  localparam bit c_BYPASS = 1'b1;
`else
  localparam bit c_BYPASS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  alu_operand_stage_if #(.DW(DW), .AW(AW), .OPW(OPW)) ifc ();

  alu_operand_stage #(.DW(DW), .AW(AW), .OPW(OPW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  always #5 clk = ~clk;

  // Reference ALU behaviour, also used as the external ALU.
  function automatic logic [DW-1:0] alu_ref(input logic [OPW-1:0] op,
                                            input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    case (op)
      5'd1:    return a + b;
      5'd2:    return a - b;
      5'd3:    return a & b;
      5'd4:    return a | b;
      5'd5:    return a ^ b;
      5'd6:    return ~(a | b);
      default: return '0;
    endcase
  endfunction

  assign ifc.alu_out = alu_ref(ifc.alu_op, ifc.alu_a, ifc.alu_b);

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic v, input int op, input int ra, input int rb, input int rd);
    ifc.in_valid = v;
    ifc.in_op    = OPW'(op);
    ifc.in_ra    = AW'(ra);
    ifc.in_rb    = AW'(rb);
    ifc.in_rd    = AW'(rd);
  endtask

  task automatic dbg(input string tag, input int addr, input logic [DW-1:0] exp);
    ifc.dbg_addr = AW'(addr);
    #1;
    chk(tag, ifc.dbg_data, exp);
  endtask

  task automatic load(input int addr, input logic [DW-1:0] data);
    ifc.ld_en   = 1'b1;
    ifc.ld_addr = AW'(addr);
    ifc.ld_data = data;
    tick();
    ifc.ld_en   = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] arch [0:7];
    logic          pv;
    logic [OPW-1:0] pop;
    int            prd;
    logic [DW-1:0] pres;

    cmd(1'b0, 0, 0, 0, 0);
    ifc.ld_en = 1'b0; ifc.ld_addr = '0; ifc.ld_data = '0; ifc.dbg_addr = '0;
    rst = 1'b1;
    tick(); tick();

    // Reset state
    chk("rst_in_ready", 32'(ifc.in_ready), 0);
    chk("rst_alu_a", ifc.alu_a, 0);
    chk("rst_alu_op", 32'(ifc.alu_op), 0);
    chk("rst_wb_valid", 32'(ifc.wb_valid), 0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(ifc.in_ready), 1);

    // 1: loads and basic ADD
    load(1, 29);
    load(2, 12);
    dbg("t1_dbg_r1", 1, 29);
    cmd(1'b1, 1, 1, 2, 3);
    tick();
    cmd(1'b0, 0, 0, 0, 0);
    chk("t1_alu_a", ifc.alu_a, 29);
    chk("t1_alu_b", ifc.alu_b, 12);
    chk("t1_alu_op", 32'(ifc.alu_op), 1);
    chk("t1_no_wb_yet", 32'(ifc.wb_valid), 0);
    tick();
    chk("t1_wb_valid", 32'(ifc.wb_valid), 1);
    chk("t1_wb_rd", 32'(ifc.wb_rd), 3);
    chk("t1_wb_data", ifc.wb_data, 41);
    dbg("t1_dbg_r3", 3, 41);

    // 2: back-to-back dependent ADD then SUB
    cmd(1'b1, 1, 1, 2, 3);
    tick();
    cmd(1'b1, 2, 3, 2, 4);
    #1;
    chk("t2_ready", 32'(ifc.in_ready), 32'(c_BYPASS));
    tick();
    chk("t2_add_wb", ifc.wb_data, 41);
    if (!c_BYPASS) begin
      chk("t2_bubble_op", 32'(ifc.alu_op), 0);
      chk("t2_ready_after", 32'(ifc.in_ready), 1);
      tick();
    end
    cmd(1'b0, 0, 0, 0, 0);
    chk("t2_alu_a", ifc.alu_a, 41);
    chk("t2_alu_b", ifc.alu_b, 12);
    chk("t2_alu_op", 32'(ifc.alu_op), 2);
    tick();
    chk("t2_wb_valid", 32'(ifc.wb_valid), 1);
    chk("t2_wb_rd", 32'(ifc.wb_rd), 4);
    chk("t2_wb_data", ifc.wb_data, 29);

    // 3: write to r0 pulses wb but is discarded
    cmd(1'b1, 1, 1, 2, 0);
    tick();
    cmd(1'b0, 0, 0, 0, 0);
    tick();
    chk("t3_wb_valid", 32'(ifc.wb_valid), 1);
    chk("t3_wb_data", ifc.wb_data, 41);
    dbg("t3_dbg_r0", 0, 0);
    cmd(1'b1, 1, 0, 1, 5);
    tick();
    cmd(1'b0, 0, 0, 0, 0);
    chk("t3_r0_read", ifc.alu_a, 0);
    tick();
    chk("t3_r5_wb", ifc.wb_data, 29);

    // 4: NOP issues but never writes back
    cmd(1'b1, 0, 1, 1, 5);
    tick();
    cmd(1'b0, 0, 0, 0, 0);
    chk("t4_alu_op", 32'(ifc.alu_op), 0);
    tick();
    chk("t4_no_wb", 32'(ifc.wb_valid), 0);
    dbg("t4_r5_kept", 5, 29);

    // 6: load collides with writeback; dependent issue while stalled
    cmd(1'b1, 1, 1, 2, 3);
    tick();
    ifc.ld_en = 1'b1; ifc.ld_addr = 3; ifc.ld_data = 7;
    cmd(1'b1, 1, 3, 1, 6);
    #1;
    chk("t6_ready", 32'(ifc.in_ready), 32'(c_BYPASS));
    tick();
    ifc.ld_en = 1'b0;
    cmd(1'b0, 0, 0, 0, 0);
    chk("t6_wb_data", ifc.wb_data, 41);
    if (c_BYPASS) chk("t6_fwd_a", ifc.alu_a, 41);
    else          chk("t6_not_taken", 32'(ifc.alu_op), 0);
    dbg("t6_wb_wins", 3, 41);
    tick();

    // load and issue reading the same register in one cycle sees the old value
    ifc.ld_en = 1'b1; ifc.ld_addr = 7; ifc.ld_data = 99;
    cmd(1'b1, 1, 7, 0, 6);
    tick();
    ifc.ld_en = 1'b0;
    cmd(1'b0, 0, 0, 0, 0);
    chk("ld_old_value", ifc.alu_a, 0);
    dbg("ld_new_value", 7, 99);
    tick();

    // 5: reset with an ADD in E
    cmd(1'b1, 1, 1, 2, 3);
    tick();
    cmd(1'b0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    chk("t5_ready_in_rst", 32'(ifc.in_ready), 0);
    tick();
    chk("t5_no_wb", 32'(ifc.wb_valid), 0);
    chk("t5_alu_a", ifc.alu_a, 0);
    chk("t5_alu_b", ifc.alu_b, 0);
    chk("t5_alu_op", 32'(ifc.alu_op), 0);
    dbg("t5_r1_clr", 1, 0);
    dbg("t5_r3_clr", 3, 0);
    rst = 1'b0;
    tick();

    // Random traffic against the architectural model
    arch[0] = '0;
    for (int i = 1; i < 8; i++) begin
      arch[i] = $urandom;
      load(i, arch[i]);
    end
    pv = 1'b0; pop = '0; prd = 0; pres = '0;
    for (int n = 0; n < 300; n++) begin
      int op, ra, rb, rd;
      logic v, hz, acc;
      logic [DW-1:0] ea, eb, res;
      op = $urandom_range(0, 6);
      ra = $urandom_range(0, 7);
      rb = $urandom_range(0, 7);
      rd = $urandom_range(0, 7);
      v  = ($urandom_range(0, 3) != 0);
      if (n >= 295) v = 1'b0;
      cmd(v, op, ra, rb, rd);
      #1;
      hz = pv && (pop != 0) && (prd != 0) && (ra == prd || rb == prd);
      chk("rnd_ready", 32'(ifc.in_ready), 32'(c_BYPASS || !hz));
      acc = v && (c_BYPASS || !hz);
      ea  = arch[ra];
      eb  = arch[rb];
      res = alu_ref(OPW'(op), ea, eb);
      tick();
      chk("rnd_wb_valid", 32'(ifc.wb_valid), 32'(pv && pop != 0));
      if (pv && pop != 0) begin
        chk("rnd_wb_rd", 32'(ifc.wb_rd), prd);
        chk("rnd_wb_data", ifc.wb_data, pres);
      end
      if (acc) begin
        chk("rnd_alu_op", 32'(ifc.alu_op), op);
        chk("rnd_alu_a", ifc.alu_a, ea);
        chk("rnd_alu_b", ifc.alu_b, eb);
        if (op != 0 && rd != 0) arch[rd] = res;
      end else begin
        chk("rnd_idle_op", 32'(ifc.alu_op), 0);
      end
      pv = acc; pop = OPW'(op); prd = rd; pres = res;
    end
    cmd(1'b0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      dbg("rnd_final_reg", i, arch[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
